// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and widths for the tri-state pad bus arbiter.
// Holds the FSM encoding, counter widths and the round-robin pointer helper.
package tristate_arb_pkg;

   localparam int TURN_W = 4;
   localparam int HOLD_W = 8;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_e;

   // Advance an owner index by one, wrapping at the number of requesters.
   function automatic logic [IDX_W-1:0] wrap_inc(logic [IDX_W-1:0] idx, int n);
      if (int'(idx) + 1 >= n) return '0;
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Requester/pad-side signal bundle of the tri-state bus arbiter.
// The arbiter uses the master view; requester logic and pad ring use the slave view.
interface tristate_bus_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   import tristate_arb_pkg::*;

   logic               DIS;
   logic [N-1:0]       REQ;
   logic [N*W-1:0]     D;
   logic [N-1:0]       GNT;
   logic [IDX_W-1:0]   OWNER;
   logic               BUSY;
   logic [W-1:0]       PAD_I;
   logic [W-1:0]       PAD_T;

   modport master (
      input  DIS, REQ, D,
      output GNT, OWNER, BUSY, PAD_I, PAD_T
   );

   modport slave (
      output DIS, REQ, D,
      input  GNT, OWNER, BUSY, PAD_I, PAD_T
   );

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// otherwise the lowest set request (wrap-around search).
module rr_pick
   import tristate_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [N-1:0]     win_oh,
   output logic [IDX_W-1:0] win_idx
);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      valid   = 1'b0;
      win_oh  = '0;
      win_idx = '0;
      for (int j = 0; j < N; j++) begin
         if (!valid && req[j] && (j >= int'(ptr))) begin
            valid     = 1'b1;
            win_oh[j] = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
      // Nothing at or above the pointer: wrap and take the lowest request.
      for (int j = 0; j < N; j++) begin
         if (!valid && req[j]) begin
            valid     = 1'b1;
            win_oh[j] = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state pad bus with mandatory high-Z
// turnaround between owners, optional hold limit and a global disable.
module tristate_bus_arbiter
   import tristate_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TURN    = 2,
   parameter int MAXHOLD = 0
) (
   input logic                  C,
   input logic                  R,
   tristate_bus_arbiter_if.master bus
);

   localparam logic [TURN_W-1:0] TURN_LD  = TURN_W'(TURN);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAXHOLD);
   localparam bit                HOLD_EN  = (MAXHOLD != 0);

   state_e             state_q, state_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               pad_t_q, pad_t_d;
   logic [TURN_W-1:0]  turn_q, turn_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic               pick_valid;
   logic [N-1:0]       pick_oh;
   logic [IDX_W-1:0]   pick_idx;

   logic               grant_ok;
   logic               do_grant;
   logic               owner_req;
   logic               others_req;
   logic               hold_hit;

   rr_pick #(.N(N)) u_pick (
      .req     (bus.REQ),
      .ptr     (ptr_q),
      .valid   (pick_valid),
      .win_oh  (pick_oh),
      .win_idx (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      pad_t_d  = pad_t_q;
      turn_d   = turn_q;
      hold_d   = hold_q;
      do_grant = 1'b0;

      // Disable outranks any request, so it simply masks the grant decision.
      grant_ok   = pick_valid && !bus.DIS;
      owner_req  = |(bus.REQ & gnt_q);
      others_req = |(bus.REQ & ~gnt_q);
      hold_hit   = HOLD_EN && (hold_q >= HOLD_LIM) && others_req;

      unique case (state_q)
         ST_IDLE: begin
            do_grant = grant_ok;
         end
         ST_OWN: begin
            if (bus.DIS || !owner_req || hold_hit) begin
               state_d = ST_TURN;
               gnt_d   = '0;
               pad_t_d = 1'b1;
               turn_d  = TURN_LD;
               hold_d  = '0;
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_TURN: begin
            if (turn_q <= TURN_W'(1)) begin
               turn_d   = '0;
               state_d  = ST_IDLE;
               do_grant = grant_ok;
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The pointer moves past the winner, so the previous owner only wins
      // again when nobody else is asking.
      if (do_grant) begin
         state_d = ST_OWN;
         gnt_d   = pick_oh;
         owner_d = pick_idx;
         ptr_d   = wrap_inc(pick_idx, N);
         pad_t_d = 1'b0;
         hold_d  = HOLD_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge C) begin
      if (R) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         pad_t_q <= 1'b1;
         turn_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         pad_t_q <= pad_t_d;
         turn_q  <= turn_d;
         hold_q  <= hold_d;
      end
   end

   // Data follows the registered one-hot grant; zero whenever the bus is high-Z.
   always_comb begin
      bus.PAD_I = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_q[i] && !pad_t_q) bus.PAD_I = bus.D[i*W +: W];
      end
   end

   assign bus.GNT   = gnt_q;
   assign bus.OWNER = owner_q;
   assign bus.PAD_T = {W{pad_t_q}};
   assign bus.BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two instances (unlimited hold and MAXHOLD=4)
// share stimulus and are compared every cycle against an integer bus-ownership model.
module tb_tristate_bus_arbiter;
   import tristate_arb_pkg::*;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int TURN = 2;
   localparam int MH   = 4;

   logic           C = 1'b0;
   logic           r;
   logic           dis;
   logic [N-1:0]   req;
   logic [N*W-1:0] d;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: owner index (-1 = nobody), high-Z cycles left, cycles held,
   // last owner, next search start. Index 0 = unlimited hold, 1 = MAXHOLD=MH.
   int m_gnt  [2];
   int m_gap  [2];
   int m_held [2];
   int m_last [2];
   int m_ptr  [2];
   int m_max  [2] = '{0, MH};

   always #5 C = ~C;

   tristate_bus_arbiter_if #(.N(N), .W(W)) bif0 ();
   tristate_bus_arbiter_if #(.N(N), .W(W)) bif4 ();

   assign bif0.DIS = dis;
   assign bif0.REQ = req;
   assign bif0.D   = d;
   assign bif4.DIS = dis;
   assign bif4.REQ = req;
   assign bif4.D   = d;

   tristate_bus_arbiter #(.N(N), .W(W), .TURN(TURN), .MAXHOLD(0)) dut0 (
      .C   (C),
      .R   (r),
      .bus (bif0)
   );

   tristate_bus_arbiter #(.N(N), .W(W), .TURN(TURN), .MAXHOLD(MH)) dut4 (
      .C   (C),
      .R   (r),
      .bus (bif4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k);
      logic [N-1:0] others;
      bit           found;
      int           c;
      if (r) begin
         m_gnt[k]  = -1;
         m_gap[k]  = 0;
         m_held[k] = 0;
         m_last[k] = 0;
         m_ptr[k]  = 0;
      end else if (m_gnt[k] >= 0) begin
         others = req;
         others[m_gnt[k]] = 1'b0;
         if (dis || !req[m_gnt[k]] ||
             (m_max[k] != 0 && m_held[k] >= m_max[k] && others != 0)) begin
            m_gnt[k]  = -1;
            m_gap[k]  = TURN;
            m_held[k] = 0;
         end else if (m_held[k] < 255) begin
            m_held[k]++;
         end
      end else if (m_gap[k] > 1) begin
         m_gap[k]--;
      end else begin
         m_gap[k] = 0;
         found = 1'b0;
         if (!dis) begin
            for (int i = 0; i < N; i++) begin
               c = (m_ptr[k] + i) % N;
               if (!found && req[c]) begin
                  found     = 1'b1;
                  m_gnt[k]  = c;
                  m_last[k] = c;
                  m_held[k] = 1;
                  m_ptr[k]  = (c + 1) % N;
               end
            end
         end
      end
   endtask

   task automatic compare_model(input int k);
      logic [N-1:0] g;
      logic [W-1:0] pt;
      logic [W-1:0] pi;
      logic [2:0]   ow;
      logic         b;
      logic [31:0]  e_gnt;
      logic [31:0]  e_pi;
      if (k == 0) begin
         g = bif0.GNT; pt = bif0.PAD_T; pi = bif0.PAD_I; ow = bif0.OWNER; b = bif0.BUSY;
      end else begin
         g = bif4.GNT; pt = bif4.PAD_T; pi = bif4.PAD_I; ow = bif4.OWNER; b = bif4.BUSY;
      end
      e_gnt = (m_gnt[k] >= 0) ? (32'd1 << m_gnt[k]) : 32'd0;
      e_pi  = (m_gnt[k] >= 0) ? 32'(d[m_gnt[k]*W +: W]) : 32'd0;
      check($sformatf("m%0d_gnt", k),   32'(g),  e_gnt);
      check($sformatf("m%0d_pad_t", k), 32'(pt), (m_gnt[k] >= 0) ? 32'h00 : 32'hFF);
      check($sformatf("m%0d_pad_i", k), 32'(pi), e_pi);
      check($sformatf("m%0d_owner", k), 32'(ow), 32'(m_last[k]));
      check($sformatf("m%0d_busy", k),  32'(b),  32'((m_gnt[k] >= 0) || (m_gap[k] > 0)));
      check($sformatf("m%0d_onehot", k), 32'($countones(g) <= 1), 32'd1);
      check($sformatf("m%0d_padt_gnt", k), 32'((pt == '0) == (g != '0)), 32'd1);
   endtask

   task automatic cycle();
      @(posedge C);
      model_step(0);
      model_step(1);
      #1;
      compare_model(0);
      compare_model(1);
   endtask

   logic [N-1:0] g4_seq [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
   int           rr_exp [5]  = '{0, 1, 2, 3, 0};

   initial begin
      int          grants;
      int          gap;
      int          budget;
      logic [N-1:0] prev;

      r   = 1'b1;
      dis = 1'b0;
      req = '0;
      d   = 32'hA1B2_C3D4;

      // Reset state
      cycle();
      cycle();
      check("rst_gnt",   32'(bif0.GNT),   32'h0);
      check("rst_pad_t", 32'(bif0.PAD_T), 32'hFF);
      check("rst_owner", 32'(bif0.OWNER), 32'h0);
      check("rst_busy",  32'(bif0.BUSY),  32'h0);
      check("rst_pad_i", 32'(bif0.PAD_I), 32'h0);

      // Single owner, then release through two high-Z cycles into idle
      r   = 1'b0;
      cycle();
      req = 4'b0001;
      cycle();
      check("single_gnt",   32'(bif0.GNT),   32'h1);
      check("single_pad_t", 32'(bif0.PAD_T), 32'h00);
      check("single_pad_i", 32'(bif0.PAD_I), 32'hD4);
      cycle();
      cycle();
      req = 4'b0000;
      cycle();
      check("rel_pad_t", 32'(bif0.PAD_T), 32'hFF);
      check("rel_gnt",   32'(bif0.GNT),   32'h0);
      check("rel_busy1", 32'(bif0.BUSY),  32'h1);
      cycle();
      check("rel_busy2", 32'(bif0.BUSY),  32'h1);
      cycle();
      check("rel_idle",  32'(bif0.BUSY),  32'h0);

      // Round-robin handoff with all requesting (hold-limited instance)
      r = 1'b1;
      cycle();
      r   = 1'b0;
      req = 4'b1111;
      grants = 0;
      gap    = 0;
      budget = 0;
      prev   = '0;
      while (grants < 5 && budget < 80) begin
         cycle();
         budget++;
         if (bif4.GNT == '0) begin
            gap++;
         end else if (prev == '0) begin
            check($sformatf("rr_owner%0d", grants), 32'(bif4.OWNER), 32'(rr_exp[grants]));
            if (grants > 0) check($sformatf("rr_gap%0d", grants), 32'(gap), 32'(TURN));
            grants++;
            gap = 0;
         end
         prev = bif4.GNT;
      end
      check("rr_grants", 32'(grants), 32'd5);
      check("nohold_keeps", 32'(bif0.GNT), 32'h1);

      // Forced release at the hold limit vs unlimited hold
      r = 1'b1;
      cycle();
      r   = 1'b0;
      req = 4'b0011;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check($sformatf("force_g4_%0d", i), 32'(bif4.GNT), 32'(g4_seq[i]));
         check($sformatf("force_g0_%0d", i), 32'(bif0.GNT), 32'h1);
      end

      // Global disable mid-ownership
      r = 1'b1;
      cycle();
      r   = 1'b0;
      req = 4'b1111;
      cycle();
      cycle();
      dis = 1'b1;
      cycle();
      check("dis_gnt",   32'(bif0.GNT),   32'h0);
      check("dis_pad_t", 32'(bif0.PAD_T), 32'hFF);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check($sformatf("dis_hold%0d", i), 32'(bif4.GNT | bif0.GNT), 32'h0);
      end
      dis = 1'b0;
      cycle();
      check("dis_resume0", 32'(bif0.GNT), 32'h2);
      check("dis_resume4", 32'(bif4.GNT), 32'h2);

      // Reset in the middle of requester 2's ownership
      r = 1'b1;
      cycle();
      r   = 1'b0;
      req = 4'b0100;
      cycle();
      check("rmid_own", 32'(bif0.OWNER), 32'h2);
      cycle();
      r = 1'b1;
      cycle();
      check("rmid_gnt",   32'(bif0.GNT),   32'h0);
      check("rmid_pad_t", 32'(bif0.PAD_T), 32'hFF);
      check("rmid_owner", 32'(bif0.OWNER), 32'h0);
      r = 1'b0;
      cycle();
      check("rmid_regrant", 32'(bif0.GNT), 32'h4);

      // Randomised traffic, disable and reset against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         dis = ($urandom_range(0, 15) == 0);
         r   = ($urandom_range(0, 63) == 0);
         d   = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Shares one bidirectional pad bus, built from W tri-state output buffers, among N internal requesters.
- Grants the bus round-robin and drives the buffer enables T (1 = high-Z) and data I for the pad buffers.
- Inserts mandatory high-Z turnaround cycles between owners so two drivers never overlap.
- Sits between requester logic and the pad-buffer ring; has a global disable input analogous to a global tri-state.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, pad bus width.
- TURN, 2, high-Z turnaround cycles between owners (1..15; 0 illegal).
- MAXHOLD, 0, max consecutive OWN cycles before forced release when another REQ is pending; 0 = unlimited (8-bit counter).

Ports:
- C  in  1  clock; all state updates on rising edge.
- R  in  1  reset, synchronous, active-high.
- DIS  in  1  synchronous global disable: forces bus high-Z, drops grant.
- REQ  in  N  request per requester; level, held while bus wanted.
- D  in  N*W  per-requester data; slice i = D[i*W +: W].
- GNT  out  N  one-hot grant (registered).
- OWNER  out  3  index of current/last owner (registered).
- BUSY  out  1  1 while in OWN or TURN.
- PAD_I  out  W  data to the pad buffer I pins.
- PAD_T  out  W  enables to the pad buffer T pins; all bits equal.

Behaviour:
- Reset (R=1 at edge): state IDLE, GNT=0, PAD_T=all 1, OWNER=0, rr pointer=0, turn/hold counters=0, BUSY=0; takes effect at the next edge, including mid-OWN.
- Registered outputs: PAD_T, GNT and OWNER are registers. PAD_I is a combinational mux D[OWNER], forced 0 when PAD_T=1.
- Arbitration: round-robin, searching from pointer upward with wrap. Pointer becomes winner+1 (mod N) on each grant.
- IDLE:
  - REQ!=0 and DIS=0 at edge k -> OWN from edge k+1: GNT[winner]=1, PAD_T=0.
  - No turnaround is needed from IDLE, because the bus is already high-Z.
- OWN:
  - Hold counter increments each cycle.
  - Release at the next edge when REQ[OWNER]=0.
  - Also release when MAXHOLD!=0, the hold count has reached MAXHOLD, and any other REQ bit is set.
  - Release -> TURN, GNT=0, PAD_T=all 1, turn counter loaded with TURN.
- TURN:
  - PAD_T=1 for exactly TURN cycles.
  - Arbitration is evaluated on the last TURN cycle: REQ!=0 -> OWN with the new winner; else IDLE.
  - The previous owner may win again only if no other requester is pending.
- DIS:
  - DIS=1 in OWN -> TURN at the next edge.
  - In IDLE or TURN, no grant is issued while DIS=1; TURN completes into IDLE.
  - PAD_T never goes 0 on the cycle after an edge where DIS=1.
- Simultaneous events:
  - R beats DIS, and DIS beats REQ.
  - Owner drops REQ at the same edge the hold limit is hit: treated as a normal release with no double count.
- Invariant: popcount(GNT)<=1; PAD_T=0 iff GNT!=0.
- REQ for out-of-range bits (N<8) does not exist; OWNER upper bits are 0.

Decomposition:
- Shared package/include tristate_arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_OWN=2'd1, ST_TURN=2'd2.
  - counter widths: turn counter 4 bits, hold counter 8 bits.
- One sub-module rr_pick (N-bit request, pointer -> one-hot winner plus index, combinational).
- The FSM, counters and output registers stay in the top.

Test Plan (N=4, W=8, TURN=2):
- Single owner: R for 2 cycles, then REQ=0001 at edge 5 -> GNT=0001 and PAD_T=FF->00 at edge 6; PAD_I=D[0]. Drop REQ at edge 10 -> PAD_T=FF at 11, IDLE at 13.
- Round-robin handoff: REQ=1111 held -> owners 0,1,2,3,0 in order. Each handoff shows exactly 2 cycles with PAD_T=FF and GNT=0000, never overlapping grants.
- Forced release: MAXHOLD=4, REQ=0011 held -> owner 0 for 4 cycles, 2 TURN cycles, then owner 1 for 4.
- With MAXHOLD=0 and the same REQ=0011, owner 0 holds indefinitely.
- Disable: DIS=1 mid-OWN -> next edge GNT=0000, PAD_T=FF. While DIS=1 with REQ=1111 there is no grant. DIS=0 -> grant resumes after the TURN cycles complete.
- Reset mid-OWN: R=1 during OWN of requester 2 -> next edge GNT=0, PAD_T=FF, OWNER=0, pointer=0. After R=0 with REQ=0100 -> owner 2 granted one cycle later.
